// File: rtl/immediate_pkg.sv
// rtl/immediate_pkg.sv - shared immediate-format constants for the encode and decode paths
//
// Purpose: single source for opcode values, field widths and legal immediate
// ranges so the encoder and the decode path agree on the immediate format.
// Contents: width localparams, default branch opcodes, range limits,
// encoder result struct, is_branch helper.

package immediate_pkg;

    localparam int OPCODE_W = 6;
    localparam int IMM_W    = 10;
    localparam int VALUE_W  = 16;
    localparam int INSTR_W  = IMM_W + OPCODE_W;
    localparam int ERRCNT_W = 8;

    localparam logic [OPCODE_W-1:0] JMP_OP_DEF = 6'b001110;
    localparam logic [OPCODE_W-1:0] JZ_OP_DEF  = 6'b001101;
    localparam logic [OPCODE_W-1:0] JNZ_OP_DEF = 6'b010011;

    // Branch immediates hold a halfword offset, so the byte range doubles
    // and must be even.
    localparam int BRANCH_MIN  = -1024;
    localparam int BRANCH_MAX  = 1022;
    localparam int DEFAULT_MIN = -512;
    localparam int DEFAULT_MAX = 511;

    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

    typedef struct packed {
        logic               range_error;
        logic [INSTR_W-1:0] instruction;
    } enc_result_t;

    function automatic logic is_branch(
        input logic [OPCODE_W-1:0] opcode,
        input logic [OPCODE_W-1:0] jmp_op,
        input logic [OPCODE_W-1:0] jz_op,
        input logic [OPCODE_W-1:0] jnz_op
    );
        return (opcode == jmp_op) || (opcode == jz_op) || (opcode == jnz_op);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - small in-order valid/ready FIFO for encoded instructions
//
// Purpose: buffers encoder results between request and response sides.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_tvalid/s_tready/s_tdata   write side; push when both valid and ready
//   m_tvalid/m_tready/m_tdata   read side; head entry, pop when both high
// s_tready depends only on registered occupancy, so a same-cycle pop never
// frees space combinationally.

module instr_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    // Last popped entry, so the head outputs hold their value once empty.
    logic [WIDTH-1:0] last_q;
    logic             push;
    logic             pop;

    assign s_tready = (count < FULL_COUNT);
    assign m_tvalid = (count != '0);
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/immediate_encoder.sv
// rtl/immediate_encoder.sv - range-checks and packs immediates into 16-bit instruction words
//
// Purpose: encodes {imm10, opcode} from an opcode and a signed value,
// flags out-of-range values, buffers results in order, counts rejects.
// Ports:
//   in_clk, in_rst                 clock, asynchronous active-low reset
//   in_req_valid/ot_req_ready      request handshake
//   in_opcode, in_value            opcode and signed immediate / byte offset
//   ot_rsp_valid/in_rsp_ready      response handshake
//   ot_instruction, ot_range_error head entry of the result buffer
//   ot_error_count                 saturating count of rejected requests

module immediate_encoder
    import immediate_pkg::*;
#(
    parameter int                  FIFO_DEPTH = 2,
    parameter logic [OPCODE_W-1:0] JMP_OP     = JMP_OP_DEF,
    parameter logic [OPCODE_W-1:0] JZ_OP      = JZ_OP_DEF,
    parameter logic [OPCODE_W-1:0] JNZ_OP     = JNZ_OP_DEF
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_req_valid,
    output logic                ot_req_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic [VALUE_W-1:0]  in_value,
    output logic                ot_rsp_valid,
    input  logic                in_rsp_ready,
    output logic [INSTR_W-1:0]  ot_instruction,
    output logic                ot_range_error,
    output logic [ERRCNT_W-1:0] ot_error_count
);

    logic        branch;
    logic        legal;
    logic [IMM_W-1:0] imm10;
    enc_result_t enc;
    enc_result_t head;
    logic        accept;

    // Legality is a sign-extension check: every bit above the immediate's
    // top bit must match it. Branches drop bit 0, which must be zero.
    always_comb begin
        branch = is_branch(in_opcode, JMP_OP, JZ_OP, JNZ_OP);
        legal  = 1'b0;
        imm10  = '0;
        if (branch) begin
            legal = ~in_value[0] && (in_value[15:11] == {5{in_value[10]}});
            imm10 = in_value[10:1];
        end else begin
            legal = (in_value[15:10] == {6{in_value[9]}});
            imm10 = in_value[9:0];
        end
        enc.range_error = ~legal;
        enc.instruction = legal ? {imm10, in_opcode} : {{IMM_W{1'b0}}, in_opcode};
    end

    // Rejected requests are still pushed so responses stay 1:1 with requests.
    instr_fifo #(
        .WIDTH ($bits(enc_result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk      (in_clk),
        .rst_n    (in_rst),
        .s_tvalid (in_req_valid),
        .s_tready (ot_req_ready),
        .s_tdata  (enc),
        .m_tvalid (ot_rsp_valid),
        .m_tready (in_rsp_ready),
        .m_tdata  (head)
    );

    assign accept         = in_req_valid & ot_req_ready;
    assign ot_instruction = head.instruction;
    assign ot_range_error = head.range_error;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            ot_error_count <= '0;
        end else if (accept && enc.range_error && (ot_error_count != ERRCNT_MAX)) begin
            ot_error_count <= ot_error_count + ERRCNT_W'(1);
        end
    end

endmodule

// File: doc/immediate_encoder.md
# immediate_encoder

Instruction-side counterpart of the immediate decode path: accepts an opcode plus a 16-bit signed target value, range-checks it against the immediate format the decode path reconstructs, and packs it into a 16-bit instruction word. It sits between the program-load/assembly path and instruction memory writes. Results are buffered in a small in-order FIFO with valid/ready handshakes on both sides. A saturating error counter records rejected encodes.

## Interface
Parameters:
- FIFO_DEPTH, 2: result buffer entries; power of two, ≥2
- JMP_OP, 6'b001110: jmp opcode
- JZ_OP, 6'b001101: jz opcode
- JNZ_OP, 6'b010011: jnz opcode

Ports (one clock; reset is asynchronous and active-low):
- in_clk  input  1  clock, rising edge
- in_rst  input  1  reset, asynchronous, active-low
- in_req_valid  input  1  request present
- ot_req_ready  output  1  request accepted this cycle if valid
- in_opcode  input  6  opcode, copied to instruction[5:0]
- in_value  input  16  signed immediate / branch byte offset
- ot_rsp_valid  output  1  FIFO head valid
- in_rsp_ready  input  1  consumer takes head
- ot_instruction  output  16  encoded word at head
- ot_range_error  output  1  head entry was rejected
- ot_error_count  output  8  saturating count of rejected requests

## Operation
- Branch class (opcode ∈ {JMP_OP, JZ_OP, JNZ_OP}): legal iff in_value[0]==0 and in_value[15:11] all equal in_value[10] (range -1024..+1022, even); imm10 = in_value[10:1].
- Other opcodes: legal iff in_value[15:10] all equal in_value[9] (range -512..+511); imm10 = in_value[9:0].
- Legal: word = {imm10, in_opcode}, error=0. Illegal: word = {10'b0, in_opcode}, error=1; entry is still pushed so responses stay 1:1 with requests.
- Accept = in_req_valid & ot_req_ready; encoded {word, error} pushed at that edge.
- Pop = ot_rsp_valid & in_rsp_ready; advances head.
- ot_error_count increments on each accepted illegal request, saturates at 255, never wraps.
- Strict in-order; no drops, no reordering.

## Timing
- Reset (async assert, sync deassert by system): FIFO empty, ot_rsp_valid=0, ot_req_ready=1, ot_instruction=0, ot_range_error=0, ot_error_count=0. Reset mid-operation discards all buffered entries immediately.
- Latency: accepted at edge N → ot_rsp_valid=1 after edge N (visible cycle N+1).
- ot_req_ready = (occupancy < FIFO_DEPTH), derived from registered occupancy only; no combinational path from in_rsp_ready.
- Full: ot_req_ready=0 even if a pop occurs same cycle; next cycle ready reasserts.
- Empty: ot_rsp_valid=0; ot_instruction/ot_range_error hold last value, don't-care.
- Simultaneous push+pop when non-empty, non-full: occupancy unchanged, throughput 1/cycle.
- Head outputs stable while ot_rsp_valid=1 and in_rsp_ready=0.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.

## Structure
- Shared package immediate_pkg: opcode constants (JMP/JZ/JNZ), IMM_W=10, OPCODE_W=6, branch/default min/max constants, is_branch function; decode path to import the same constants.
- One sub-module: instr_fifo (parameterised width/depth, valid/ready, async active-low reset). Encode/range check stays combinational in the top.

## Test plan
- jmp, in_value=16'hFFFC (-4) → ot_instruction=16'hFF8E, ot_range_error=0, one cycle after accept.
- opcode 6'b000001, in_value=511 → 16'h7FC1, err 0; in_value=512 → 16'h0001, err 1, ot_error_count=1.
- jz, in_value=3 (odd) → 16'h000D, err 1; jnz, in_value=1022 → 16'h7FD3, err 0; jnz, 1024 → 16'h0013, err 1.
- Backpressure: in_rsp_ready=0, three back-to-back requests → two accepted, ot_req_ready=0 from cycle after 2nd; release → responses in request order, third accepted.
- 300 illegal requests → ot_error_count saturates at 255.
- in_rst low with 2 entries buffered → ot_rsp_valid=0 and ot_req_ready=1 without clock edge; count=0.
